// File: rtl/cpu_irq_pkg.sv
// rtl/cpu_irq_pkg.sv - shared register map, FSM encoding and helpers for the interrupt controller
package cpu_irq_pkg;

  // Register word offsets relative to the controller base address
  localparam logic [15:0] IRQ_PENDING  = 16'd0;
  localparam logic [15:0] IRQ_MASK     = 16'd1;
  localparam logic [15:0] IRQ_EOI      = 16'd2;
  localparam logic [15:0] IRQ_CLAIM    = 16'd3;
  localparam logic [15:0] IRQ_SWSET    = 16'd4;
  localparam logic [15:0] IRQ_NUM_REGS = 16'd5;

  // Default placement and vector numbering
  localparam logic [15:0] IRQ_BASE_ADDR   = 16'hFF00;
  localparam logic [7:0]  IRQ_VECTOR_BASE = 8'h10;
  localparam int          IRQ_MAX_SRC     = 16;

  typedef enum logic [1:0] {
    IRQ_IDLE   = 2'd0,
    IRQ_ASSERT = 2'd1,
    IRQ_INSERV = 2'd2
  } irq_state_t;

  // Vector number presented to the core; wraps at 8 bits
  function automatic logic [7:0] irq_vector(input logic [7:0] base, input logic [3:0] idx);
    return base + {4'b0000, idx};
  endfunction

endpackage

// File: rtl/irq_controller_if.sv
// rtl/irq_controller_if.sv - core RAM-bus port shared by the core and the interrupt controller
interface irq_controller_if;
  logic [15:0] address;
  logic [31:0] data;
  logic        wren;
  logic [31:0] rdata;
  logic        rd_hit;

  // The core drives address/data/wren and consumes the registered read response
  modport master (
    output address,
    output data,
    output wren,
    input  rdata,
    input  rd_hit
  );

  modport slave (
    input  address,
    input  data,
    input  wren,
    output rdata,
    output rd_hit
  );
endinterface

// File: rtl/irq_prio_enc.sv
// rtl/irq_prio_enc.sv - lowest-index-wins priority encoder over the request vector
module irq_prio_enc #(
  parameter int N_SRC = 8
) (
  input  logic [N_SRC-1:0] req,
  output logic             any,
  output logic [3:0]       idx
);

  // Scan from the top down so the lowest set index is the last one written
  always_comb begin
    any = |req;
    idx = 4'd0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx = 4'(i);
      end
    end
  end

endmodule

// File: rtl/irq_controller.sv
// rtl/irq_controller.sv - edge-latched, maskable, fixed-priority interrupt controller
module irq_controller
  import cpu_irq_pkg::*;
#(
  parameter int          N_SRC       = 8,
  parameter logic [15:0] BASE_ADDR   = IRQ_BASE_ADDR,
  parameter logic [7:0]  VECTOR_BASE = IRQ_VECTOR_BASE
) (
  input  logic             clk,
  input  logic             nreset,
  irq_controller_if.slave  bus,
  input  logic [N_SRC-1:0] irq_src,
  output logic             IRQ,
  output logic [7:0]       IRQn
);

  logic [N_SRC-1:0] src_q;
  logic [N_SRC-1:0] pending;
  logic [N_SRC-1:0] mask;
  logic [N_SRC-1:0] src_rise;
  logic [N_SRC-1:0] set_bits;
  logic [N_SRC-1:0] w1c_bits;
  logic [N_SRC-1:0] claim_bits;
  logic [N_SRC-1:0] pending_keep;
  logic [N_SRC-1:0] pending_n;
  logic [N_SRC-1:0] mask_n;
  logic [N_SRC-1:0] cur_bit;

  logic [3:0]  cur;
  logic [3:0]  cur_n;
  logic [3:0]  enc_idx;
  logic        enc_any;
  irq_state_t  state;
  irq_state_t  state_n;
  logic        irq_n;
  logic [7:0]  irqn_n;

  logic [15:0] offset;
  logic        reg_hit;
  logic        rd_any;
  logic        wr_pending;
  logic        wr_mask;
  logic        wr_eoi;
  logic        wr_swset;
  logic        claim_fire;
  logic        cur_live;
  logic [31:0] rd_value;
  logic        unused_data;

  // Upper data bits only matter for wider configurations
  assign unused_data = ^bus.data;

  // Address decode: the wrapped offset keeps the window check a single compare
  assign offset     = bus.address - BASE_ADDR;
  assign reg_hit    = (offset < IRQ_NUM_REGS);
  assign rd_any     = reg_hit & ~bus.wren;
  assign wr_pending = reg_hit & bus.wren & (offset == IRQ_PENDING);
  assign wr_mask    = reg_hit & bus.wren & (offset == IRQ_MASK);
  assign wr_eoi     = reg_hit & bus.wren & (offset == IRQ_EOI);
  assign wr_swset   = reg_hit & bus.wren & (offset == IRQ_SWSET);
  assign claim_fire = rd_any & (offset == IRQ_CLAIM) & (state == IRQ_ASSERT);

  // One-hot view of the source currently being offered to the core
  always_comb begin
    cur_bit = '0;
    for (int i = 0; i < N_SRC; i++) begin
      cur_bit[i] = (cur == 4'(i));
    end
  end

  // Pending update: clears apply first and sets are OR-ed last so a same-cycle set always wins
  always_comb begin
    src_rise     = irq_src & ~src_q;
    set_bits     = src_rise | (wr_swset ? bus.data[N_SRC-1:0] : '0);
    w1c_bits     = wr_pending ? bus.data[N_SRC-1:0] : '0;
    claim_bits   = claim_fire ? cur_bit : '0;
    pending_keep = (pending & ~w1c_bits) | set_bits;
    pending_n    = (pending_keep & ~claim_bits) | set_bits;
    mask_n       = wr_mask ? bus.data[N_SRC-1:0] : mask;
    cur_live     = |(pending_keep & mask_n & cur_bit);
  end

  irq_prio_enc #(
    .N_SRC (N_SRC)
  ) u_prio_enc (
    .req (pending & mask),
    .any (enc_any),
    .idx (enc_idx)
  );

  // Source sampling, pending latch and mask register
  always_ff @(posedge clk) begin
    if (!nreset) begin
      src_q   <= '0;
      pending <= '0;
      mask    <= '0;
    end else begin
      src_q   <= irq_src;
      pending <= pending_n;
      mask    <= mask_n;
    end
  end

  // Service FSM next state; IRQn only changes when a new source is accepted
  always_comb begin
    state_n = state;
    cur_n   = cur;
    irq_n   = IRQ;
    irqn_n  = IRQn;
    case (state)
      IRQ_IDLE: begin
        if (enc_any) begin
          cur_n   = enc_idx;
          irq_n   = 1'b1;
          irqn_n  = irq_vector(VECTOR_BASE, enc_idx);
          state_n = IRQ_ASSERT;
        end
      end
      IRQ_ASSERT: begin
        if (claim_fire) begin
          irq_n   = 1'b0;
          state_n = IRQ_INSERV;
        end else if (!cur_live) begin
          irq_n   = 1'b0;
          state_n = IRQ_IDLE;
        end
      end
      IRQ_INSERV: begin
        if (wr_eoi) begin
          state_n = IRQ_IDLE;
        end
      end
      default: begin
        irq_n   = 1'b0;
        state_n = IRQ_IDLE;
      end
    endcase
  end

  // Service FSM registers
  always_ff @(posedge clk) begin
    if (!nreset) begin
      state <= IRQ_IDLE;
      cur   <= 4'd0;
      IRQ   <= 1'b0;
      IRQn  <= 8'd0;
    end else begin
      state <= state_n;
      cur   <= cur_n;
      IRQ   <= irq_n;
      IRQn  <= irqn_n;
    end
  end

  // Read mux over the values held before this edge's updates
  always_comb begin
    rd_value = 32'd0;
    case (offset)
      IRQ_PENDING: rd_value = 32'(pending);
      IRQ_MASK:    rd_value = 32'(mask);
      IRQ_CLAIM:   rd_value = {(state == IRQ_INSERV), 23'd0, IRQn};
      default:     rd_value = 32'd0;
    endcase
  end

  // Registered read response, lined up with the RAM's one-cycle latency
  always_ff @(posedge clk) begin
    if (!nreset) begin
      bus.rdata  <= 32'd0;
      bus.rd_hit <= 1'b0;
    end else begin
      bus.rdata  <= rd_any ? rd_value : 32'd0;
      bus.rd_hit <= rd_any;
    end
  end

endmodule

// File: tb/tb_irq_controller.sv
// tb/tb_irq_controller.sv - randomized and directed self-checking bench for irq_controller
module tb_irq_controller;
  import cpu_irq_pkg::*;

  localparam int          N    = 8;
  localparam logic [15:0] BASE = 16'hFF00;
  localparam logic [7:0]  VB   = 8'h10;
  localparam logic [15:0] NMSK = 16'h00FF;

  logic         clk;
  logic         nreset;
  logic [N-1:0] irq_src;
  logic         irq;
  logic [7:0]   irqn;

  irq_controller_if bus_if ();

  irq_controller #(
    .N_SRC       (N),
    .BASE_ADDR   (BASE),
    .VECTOR_BASE (VB)
  ) dut (
    .clk     (clk),
    .nreset  (nreset),
    .bus     (bus_if.slave),
    .irq_src (irq_src),
    .IRQ     (irq),
    .IRQn    (irqn)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks;
  int n_fail;

  // Reference model: pending/mask as plain bit sets, service phase as two flags
  bit [15:0] m_pend;
  bit [15:0] m_mask;
  bit [15:0] m_srcq;
  bit        m_offered;
  bit        m_serving;
  bit        m_irq;
  bit [7:0]  m_irqn;
  int        m_cur;
  bit        m_rdhit;
  bit [31:0] m_rdata;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_update(input bit nr, input bit [15:0] a, input bit [31:0] d,
                              input bit w, input bit [15:0] s);
    bit [15:0] off;
    bit        hit;
    bit        rd;
    bit        claim;
    bit [15:0] rise;
    bit [15:0] setb;
    bit [15:0] clrb;
    bit [15:0] keep;
    bit [15:0] new_mask;
    bit [15:0] req;
    bit [15:0] lowbit;
    if (!nr) begin
      m_pend = 0; m_mask = 0; m_srcq = 0;
      m_offered = 0; m_serving = 0; m_irq = 0; m_irqn = 0; m_cur = 0;
      m_rdhit = 0; m_rdata = 0;
      return;
    end
    rise   = s & ~m_srcq & NMSK;
    m_srcq = s & NMSK;
    off    = a - BASE;
    hit    = off < 5;
    rd     = hit && !w;
    m_rdhit = rd;
    m_rdata = 0;
    if (rd) begin
      if (off == 0) m_rdata = {16'd0, m_pend};
      else if (off == 1) m_rdata = {16'd0, m_mask};
      else if (off == 3) m_rdata = {m_serving, 23'd0, m_irqn};
    end
    claim    = rd && (off == 3) && m_offered;
    clrb     = (w && hit && off == 0) ? (d[15:0] & NMSK) : 16'd0;
    setb     = rise | ((w && hit && off == 4) ? (d[15:0] & NMSK) : 16'd0);
    keep     = (m_pend & ~clrb) | setb;
    new_mask = (w && hit && off == 1) ? (d[15:0] & NMSK) : m_mask;
    req      = m_pend & m_mask;
    if (!m_offered && !m_serving) begin
      if (req != 0) begin
        lowbit    = req & (~req + 16'd1);
        m_cur     = $countones(lowbit - 16'd1);
        m_irq     = 1;
        m_irqn    = 8'(VB + m_cur);
        m_offered = 1;
      end
    end else if (m_offered) begin
      if (claim) begin
        m_offered = 0; m_serving = 1; m_irq = 0;
      end else if (!(keep[m_cur] && new_mask[m_cur])) begin
        m_offered = 0; m_irq = 0;
      end
    end else if (w && hit && off == 2) begin
      m_serving = 0;
    end
    m_pend = claim ? ((keep & ~(16'd1 << m_cur)) | setb) : keep;
    m_mask = new_mask;
  endtask

  // One bus cycle: drive, let the edge happen, advance the model, compare at the falling edge
  task automatic step(input bit nr, input logic [15:0] a, input logic [31:0] d,
                      input bit w, input logic [N-1:0] s);
    nreset         = nr;
    bus_if.address = a;
    bus_if.data    = d;
    bus_if.wren    = w;
    irq_src        = s;
    @(posedge clk);
    model_update(nr, a, d, w, {8'd0, s});
    @(negedge clk);
    check("irq", {31'd0, irq}, {31'd0, m_irq});
    check("irqn", {24'd0, irqn}, {24'd0, m_irqn});
    check("rd_hit", {31'd0, bus_if.rd_hit}, {31'd0, m_rdhit});
    if (m_rdhit) check("rdata", bus_if.rdata, m_rdata);
  endtask

  task automatic wr(input logic [15:0] off, input logic [31:0] d, input logic [N-1:0] s);
    step(1'b1, BASE + off, d, 1'b1, s);
  endtask

  task automatic rd(input logic [15:0] off, input logic [N-1:0] s);
    step(1'b1, BASE + off, 32'd0, 1'b0, s);
  endtask

  task automatic idle(input logic [N-1:0] s);
    step(1'b1, 16'h0100, 32'd0, 1'b0, s);
  endtask

  initial begin
    logic [N-1:0] rs;
    logic [15:0]  ra;
    int           sel;
    n_checks = 0;
    n_fail   = 0;

    // Reset state
    step(1'b0, 16'h0000, 32'd0, 1'b0, '0);
    step(1'b0, 16'h0000, 32'd0, 1'b0, '0);
    check("reset_irq", {31'd0, irq}, 32'd0);
    check("reset_irqn", {24'd0, irqn}, 32'd0);
    rd(IRQ_PENDING, '0);
    check("reset_pending", bus_if.rdata, 32'd0);
    rd(IRQ_MASK, '0);
    check("reset_mask", bus_if.rdata, 32'd0);

    // Basic flow on source 3
    wr(IRQ_MASK, 32'h0C, '0);
    idle(8'h08);
    check("basic_irq_lat", {31'd0, irq}, 32'd0);
    rd(IRQ_PENDING, 8'h00);
    check("basic_pending", bus_if.rdata, 32'h08);
    check("basic_irq", {31'd0, irq}, 32'd1);
    check("basic_irqn", {24'd0, irqn}, 32'h13);
    rd(IRQ_CLAIM, '0);
    check("basic_claim", bus_if.rdata, 32'h00000013);
    check("basic_irq_drop", {31'd0, irq}, 32'd0);
    rd(IRQ_CLAIM, '0);
    check("basic_inserv", bus_if.rdata, 32'h80000013);
    wr(IRQ_EOI, 32'hDEAD, '0);
    idle('0);
    check("basic_after_eoi", {31'd0, irq}, 32'd0);

    // Priority between simultaneous sources 5 and 2
    wr(IRQ_MASK, 32'hFF, '0);
    idle(8'h24);
    idle('0);
    check("prio_first", {24'd0, irqn}, 32'h12);
    rd(IRQ_CLAIM, '0);
    wr(IRQ_EOI, 32'd0, '0);
    idle('0);
    check("prio_second_irq", {31'd0, irq}, 32'd1);
    check("prio_second", {24'd0, irqn}, 32'h15);
    rd(IRQ_CLAIM, '0);
    wr(IRQ_EOI, 32'd0, '0);

    // Masked source latches but does not interrupt
    wr(IRQ_MASK, 32'h00, '0);
    idle(8'h02);
    idle('0);
    rd(IRQ_PENDING, '0);
    check("mask_pending", bus_if.rdata, 32'h02);
    check("mask_irq", {31'd0, irq}, 32'd0);
    wr(IRQ_MASK, 32'h02, '0);
    check("mask_irq_wr", {31'd0, irq}, 32'd0);
    idle('0);
    check("mask_irq_late", {31'd0, irq}, 32'd1);
    check("mask_irqn", {24'd0, irqn}, 32'h11);
    rd(IRQ_CLAIM, '0);
    wr(IRQ_EOI, 32'd0, '0);

    // Retract by W1C, then edge and W1C colliding on bit 4
    wr(IRQ_MASK, 32'h01, '0);
    idle(8'h01);
    idle('0);
    check("retract_irq_up", {31'd0, irq}, 32'd1);
    wr(IRQ_PENDING, 32'h01, '0);
    check("retract_irq", {31'd0, irq}, 32'd0);
    check("retract_irqn", {24'd0, irqn}, 32'h10);
    idle('0);
    wr(IRQ_PENDING, 32'h10, 8'h10);
    rd(IRQ_PENDING, '0);
    check("collide_pending", bus_if.rdata, 32'h10);
    wr(IRQ_PENDING, 32'h10, '0);

    // Reset while in service
    idle(8'h01);
    idle('0);
    rd(IRQ_CLAIM, '0);
    idle(8'h08);
    step(1'b0, 16'h0000, 32'd0, 1'b0, '0);
    check("midrst_irq", {31'd0, irq}, 32'd0);
    check("midrst_irqn", {24'd0, irqn}, 32'd0);
    rd(IRQ_MASK, '0);
    check("midrst_mask", bus_if.rdata, 32'd0);
    rd(IRQ_PENDING, '0);
    check("midrst_pending", bus_if.rdata, 32'd0);

    // Randomized traffic against the model
    rs = '0;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 3) == 0) rs = rs ^ N'($urandom);
      sel = $urandom_range(0, 11);
      if (sel <= 4) ra = BASE + 16'(sel);
      else if (sel == 5) ra = BASE + 16'd5;
      else if (sel == 6) ra = BASE - 16'd1;
      else if (sel == 7) ra = 16'($urandom);
      else ra = BASE + IRQ_CLAIM;
      step($urandom_range(0, 399) != 0, ra, $urandom, $urandom_range(0, 2) == 0, rs);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
